tdm_demux4b_1to4: RTL and testbench

//  Receive end of the lab's 4-bit 4:1 time-division link: one 4-bit stream, one

---
 rtl/tdm_demux4b_1to4_pkg.sv | 11 +
 rtl/tdm_demux4b_1to4_slot_ctr.sv | 23 ++
 rtl/tdm_demux4b_1to4.sv | 138 +++++++++++++
 tb/tb_tdm_demux4b_1to4.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4b_1to4_pkg.sv
// Shared definitions for the 4:1 TDM receive path: framing states and slot geometry.
package tdm_defs;
  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;
endpackage

// File: rtl/tdm_demux4b_1to4_slot_ctr.sv
// Modulo-4 slot counter. Priority: rst, clr, load1, inc. Wraps 3 -> 0 on inc.
module slot_ctr_mod4
  import tdm_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load1) begin
      count <= SLOT_W'(1);
    end else if (inc) begin
      count <= count + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4b_1to4.sv
// 1:4 TDM demux: routes beats into shadow lanes and publishes all four lanes on one edge
// once the slot-3 beat arrives (1 clk latency). No backpressure: every valid beat is consumed.
module tdm_demux4b_1to4
  import tdm_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_c,
  output logic [WIDTH-1:0]  out_d,
  output logic              out_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic [SLOT_W-1:0] slot
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shadow0, shadow1, shadow2;

  logic take_sync, take_beat, publish, err;
  logic ctr_clr, ctr_load1, ctr_inc;

  slot_ctr_mod4 u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .inc   (ctr_inc),
    .count (slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_HUNT;
        ST_HUNT: if (din_valid && frame_sync) state_nxt = ST_RUN;
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A sync beat mid-frame restarts the frame: it becomes slot 0 and the partial frame is dropped.
  always_comb begin
    take_sync = 1'b0;
    take_beat = 1'b0;
    publish   = 1'b0;
    err       = 1'b0;
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_inc   = 1'b0;
    if (!enable) begin
      ctr_clr = 1'b1;
    end else begin
      case (state)
        ST_HUNT: begin
          if (din_valid && frame_sync) begin
            take_sync = 1'b1;
            ctr_load1 = 1'b1;
          end
        end
        ST_RUN: begin
          if (din_valid) begin
            if (frame_sync && slot != '0) begin
              err       = 1'b1;
              take_sync = 1'b1;
              ctr_load1 = 1'b1;
            end else begin
              ctr_inc = 1'b1;
              if (slot == SLOT_W'(SLOTS - 1)) publish = 1'b1;
              else                            take_beat = 1'b1;
            end
          end
        end
        default: ctr_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow0 <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
    end else if (take_sync) begin
      shadow0 <= din;
    end else if (take_beat) begin
      case (slot)
        2'd0:    shadow0 <= din;
        2'd1:    shadow1 <= din;
        default: shadow2 <= din;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_a      <= '0;
      out_b      <= '0;
      out_c      <= '0;
      out_d      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= publish;
      sync_err   <= err;
      if (publish) begin
        out_a     <= shadow0;
        out_b     <= shadow1;
        out_c     <= shadow2;
        out_d     <= din;
        out_valid <= 1'b1;
      end else if (!enable || state == ST_IDLE) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4b_1to4.sv
// Bench for tdm_demux4b_1to4: directed framing scenarios plus randomized traffic
// checked cycle-by-cycle against a behavioural frame model.
module tb_tdm_demux4b_1to4;
  logic       clk = 1'b0;
  logic       rst, enable, din_valid, frame_sync;
  logic [3:0] din;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic       out_valid, frame_done, sync_err;
  logic [1:0] slot;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: mode 0 = idle, 1 = hunting for sync, 2 = framed.
  int         m_mode;
  int         m_slot;
  logic [3:0] m_sh [3];
  logic [3:0] m_out [4];
  logic       m_ov, m_fd, m_se;

  tdm_demux4b_1to4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_valid(out_valid), .frame_done(frame_done), .sync_err(sync_err), .slot(slot)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic e, input logic v, input logic fs,
                            input logic [3:0] d);
    if (r) begin
      m_mode = 0; m_slot = 0; m_ov = 0; m_fd = 0; m_se = 0;
      for (int i = 0; i < 3; i++) m_sh[i] = 4'h0;
      for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
    end else begin
      m_fd = 0; m_se = 0;
      if (!e) begin
        m_mode = 0; m_slot = 0; m_ov = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (v && fs) begin
          m_sh[0] = d; m_slot = 1; m_mode = 2;
        end
      end else if (v) begin
        if (fs && m_slot != 0) begin
          m_se = 1; m_sh[0] = d; m_slot = 1;
        end else if (m_slot == 3) begin
          m_out[0] = m_sh[0]; m_out[1] = m_sh[1]; m_out[2] = m_sh[2]; m_out[3] = d;
          m_fd = 1; m_ov = 1; m_slot = 0;
        end else begin
          m_sh[m_slot] = d; m_slot = m_slot + 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic fs,
                      input logic [3:0] d);
    rst = r; enable = e; din_valid = v; frame_sync = fs; din = d;
    @(posedge clk);
    model_step(r, e, v, fs, d);
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    vectors++;
    if ({out_a, out_b, out_c, out_d, out_valid, frame_done, sync_err, slot} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0",
               {out_a, out_b, out_c, out_d, out_valid, frame_done, sync_err, slot});
    end
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 4'h5);
    vectors++;
    if (slot !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_drops_nonsync got slot=%0d ov=%b want slot=0 ov=0", slot, out_valid);
    end
  endtask

  task automatic test_basic_frame;
    step(0, 1, 1, 1, 4'h1);
    vectors++;
    if (slot !== 2'd1) begin
      miscompares++;
      $display("FAIL basic_sync_slot got %0d want 1", slot);
    end
    step(0, 1, 1, 0, 4'h2);
    step(0, 1, 1, 0, 4'h4);
    step(0, 1, 1, 0, 4'h8);
    vectors++;
    if ({out_a, out_b, out_c, out_d} !== 16'h1248 || frame_done !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_publish got %h fd=%b ov=%b want 1248 fd=1 ov=1",
               {out_a, out_b, out_c, out_d}, frame_done, out_valid);
    end
    step(0, 1, 0, 0, 0);
    vectors++;
    if (frame_done !== 1'b0 || out_valid !== 1'b1 || slot !== 2'd0) begin
      miscompares++;
      $display("FAIL basic_pulse_end got fd=%b ov=%b slot=%0d want fd=0 ov=1 slot=0",
               frame_done, out_valid, slot);
    end
  endtask

  task automatic test_gaps;
    step(0, 1, 1, 1, 4'h2);
    step(0, 1, 1, 0, 4'h3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 4'hF);
      vectors++;
      if ({out_a, out_b, out_c, out_d} !== 16'h1248 || frame_done !== 1'b0 || slot !== 2'd2) begin
        miscompares++;
        $display("FAIL gap_hold got %h fd=%b slot=%0d want 1248 fd=0 slot=2",
                 {out_a, out_b, out_c, out_d}, frame_done, slot);
      end
    end
    step(0, 1, 1, 0, 4'h5);
    vectors++;
    if ({out_a, out_b, out_c, out_d} !== 16'h1248) begin
      miscompares++;
      $display("FAIL gap_no_partial got %h want 1248", {out_a, out_b, out_c, out_d});
    end
    step(0, 1, 1, 0, 4'hE);
    vectors++;
    if ({out_a, out_b, out_c, out_d} !== 16'h235E || frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_publish got %h fd=%b want 235e fd=1", {out_a, out_b, out_c, out_d}, frame_done);
    end
  endtask

  task automatic test_sync_error;
    step(0, 1, 1, 0, 4'hD);
    step(0, 1, 1, 0, 4'h8);
    step(0, 1, 1, 1, 4'hF);
    vectors++;
    if (sync_err !== 1'b1 || slot !== 2'd1 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_err_pulse got se=%b slot=%0d fd=%b want se=1 slot=1 fd=0",
               sync_err, slot, frame_done);
    end
    step(0, 1, 1, 0, 4'hA);
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_err_single got %b want 0", sync_err);
    end
    step(0, 1, 1, 0, 4'h6);
    step(0, 1, 1, 0, 4'hF);
    vectors++;
    if ({out_a, out_b, out_c, out_d} !== 16'hFA6F || frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL sync_err_frame got %h fd=%b want fa6f fd=1", {out_a, out_b, out_c, out_d}, frame_done);
    end
  endtask

  task automatic test_disable;
    step(0, 1, 1, 1, 4'h3);
    step(0, 1, 1, 0, 4'hE);
    step(0, 0, 1, 0, 4'h7);
    vectors++;
    if ({out_a, out_b, out_c, out_d} !== 16'hFA6F || out_valid !== 1'b0 || slot !== 2'd0) begin
      miscompares++;
      $display("FAIL disable_hold got %h ov=%b slot=%0d want fa6f ov=0 slot=0",
               {out_a, out_b, out_c, out_d}, out_valid, slot);
    end
    step(0, 0, 1, 1, 4'h1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 4'h9);
    step(0, 1, 1, 0, 4'h3);
    step(0, 1, 1, 0, 4'hC);
    step(0, 1, 1, 0, 4'hE);
    vectors++;
    if ({out_a, out_b, out_c, out_d} !== 16'h93CE || out_valid !== 1'b1 || frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL reenable_frame got %h ov=%b fd=%b want 93ce ov=1 fd=1",
               {out_a, out_b, out_c, out_d}, out_valid, frame_done);
    end
  endtask

  task automatic test_reset_mid_frame;
    step(0, 1, 1, 1, 4'h1);
    step(0, 1, 1, 0, 4'h2);
    step(0, 1, 1, 0, 4'h3);
    step(1, 1, 1, 0, 4'h4);
    vectors++;
    if ({out_a, out_b, out_c, out_d, out_valid, frame_done, sync_err, slot} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_on_slot3 got %h want 0",
               {out_a, out_b, out_c, out_d, out_valid, frame_done, sync_err, slot});
    end
  endtask

  task automatic test_random;
    logic       r, e, v, fs;
    logic [3:0] d;
    logic [20:0] want;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 79) == 0);
      e  = ($urandom_range(0, 29) != 0);
      v  = ($urandom_range(0, 9) < 7);
      fs = ($urandom_range(0, 6) == 0);
      d  = 4'($urandom);
      step(r, e, v, fs, d);
      want = {m_out[0], m_out[1], m_out[2], m_out[3], m_ov, m_fd, m_se, 2'(m_slot)};
      vectors++;
      if ({out_a, out_b, out_c, out_d, out_valid, frame_done, sync_err, slot} !== want) begin
        miscompares++;
        $display("FAIL random_cycle %0d got %h want %h", n,
                 {out_a, out_b, out_c, out_d, out_valid, frame_done, sync_err, slot}, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = 4'h0;
    model_step(1, 0, 0, 0, 0);
    @(negedge clk);
    test_reset;
    test_basic_frame;
    test_gaps;
    test_sync_error;
    test_disable;
    test_reset_mid_frame;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
